// File: rtl/gauss_conv3x3.sv
// 3x3 Gaussian blur ([1 2 1;2 4 2;1 2 1]/16, round-half-up) behind a window generator.
// Tracks raster position and emits one result per interior window, with coordinates and frame_done.

module gauss_row3 #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_c,
  output logic [DATA_W+1:0] o_sum
);
  assign o_sum = {2'b00, i_a} + {1'b0, i_b, 1'b0} + {2'b00, i_c};
endmodule

module gauss_conv3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  localparam int RW    = $clog2(IMG_H),
  localparam int CW    = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pixel_vld,
  input  logic              sof,
  input  logic [DATA_W-1:0] w00,
  input  logic [DATA_W-1:0] w01,
  input  logic [DATA_W-1:0] w02,
  input  logic [DATA_W-1:0] w10,
  input  logic [DATA_W-1:0] w11,
  input  logic [DATA_W-1:0] w12,
  input  logic [DATA_W-1:0] w20,
  input  logic [DATA_W-1:0] w21,
  input  logic [DATA_W-1:0] w22,
  output logic [DATA_W-1:0] blur_out,
  output logic              blur_vld,
  output logic [RW-1:0]     blur_row,
  output logic [CW-1:0]     blur_col,
  output logic              frame_done
);
  localparam int SW = DATA_W + 4;
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);

  // position of the next pixel to be accepted
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [RW-1:0] w_pr;
  logic [CW-1:0] w_pc;

  // vld_pipe[0]: pixel accepted last cycle (stage 0), vld_pipe[1]: stage 1 valid
  logic [1:0]    r_vld_pipe;
  logic [RW-1:0] r_pr0;
  logic [CW-1:0] r_pc0;
  logic          w_v0;

  logic [2:0][DATA_W-1:0] w_a, w_b, w_c;
  logic [2:0][DATA_W+1:0] w_s, r_s;
  logic [RW-1:0] r_row1;
  logic [CW-1:0] r_col1;
  logic          r_last1;
  logic [SW-1:0] w_tot;

  assign w_pr = sof ? '0 : r_row;
  assign w_pc = sof ? '0 : r_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (pixel_vld) begin
      if (sof) begin
        r_row <= '0;
        r_col <= CW'(1);
      end else if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // cols 0/1 still see the previous row's tail, rows 0/1 lack line history
  assign w_v0 = r_vld_pipe[0] && (r_pr0 >= ROW_TWO) && (r_pc0 >= COL_TWO);

  assign w_a = {w20, w10, w00};
  assign w_b = {w21, w11, w01};
  assign w_c = {w22, w12, w02};

  for (genvar g = 0; g < 3; g++) begin : g_row
    gauss_row3 #(.DATA_W(DATA_W)) u_row (
      .i_a  (w_a[g]),
      .i_b  (w_b[g]),
      .i_c  (w_c[g]),
      .o_sum(w_s[g])
    );
  end

  assign w_tot = {2'b00, r_s[0]} + {1'b0, r_s[1], 1'b0} + {2'b00, r_s[2]} + SW'(8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_pr0      <= '0;
      r_pc0      <= '0;
      r_s        <= '0;
      r_row1     <= '0;
      r_col1     <= '0;
      r_last1    <= 1'b0;
      blur_out   <= '0;
      blur_vld   <= 1'b0;
      blur_row   <= '0;
      blur_col   <= '0;
      frame_done <= 1'b0;
    end else begin
      r_vld_pipe <= {w_v0, pixel_vld};
      if (pixel_vld) begin
        r_pr0 <= w_pr;
        r_pc0 <= w_pc;
      end
      if (w_v0) begin
        r_s     <= w_s;
        r_row1  <= r_pr0 - 1'b1;
        r_col1  <= r_pc0 - 1'b1;
        r_last1 <= (r_pr0 == ROW_LAST) && (r_pc0 == COL_LAST);
      end
      blur_vld   <= r_vld_pipe[1];
      frame_done <= r_vld_pipe[1] && r_last1;
      if (r_vld_pipe[1]) begin
        blur_out <= DATA_W'(w_tot >> 4);
        blur_row <= r_row1;
        blur_col <= r_col1;
      end
    end
  end
endmodule
